clock_step_sequencer: RTL

Sequences reset release and CPU clock-enable for the whole design; sits directly downstream of the clock/reset generator.
- After reset, holds all domains in reset, then releases them in a fixed staggered order (BRAM first, then CPU, then peripherals).
- Once released, gates the CPU through a clock-enable in one of four modes: RUN, SLOW, STEP and HALT.
- Replaces the clock-divider approach for observing single cycles: the design runs on the full-speed clock, with no derived clocks.

---
 rtl/clock_step_sequencer_if.sv | 35 +++
 rtl/clock_step_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/clock_step_sequencer_if.sv
// Control/status bundle between the clock/reset generator side and the
// clock_step_sequencer. The ce_count field exists only when CE_COUNTER_EN is defined.
interface clock_step_sequencer_if #(
    parameter int NB_DOMAINS = 3
);
    logic                  sw_reset_req;
    logic [1:0]            mode;
    logic                  step;
    logic [7:0]            step_count;
    logic [NB_DOMAINS-1:0] domain_resetn;
    logic                  cpu_ce;
    logic                  busy;
    logic                  ready;
`ifdef CE_COUNTER_EN
    logic [31:0]           ce_count;

    modport master (
        output sw_reset_req, mode, step, step_count,
        input  domain_resetn, cpu_ce, busy, ready, ce_count
    );
    modport slave (
        input  sw_reset_req, mode, step, step_count,
        output domain_resetn, cpu_ce, busy, ready, ce_count
    );
`else
    modport master (
        output sw_reset_req, mode, step, step_count,
        input  domain_resetn, cpu_ce, busy, ready
    );
    modport slave (
        input  sw_reset_req, mode, step, step_count,
        output domain_resetn, cpu_ce, busy, ready
    );
`endif
endinterface

// File: rtl/clock_step_sequencer.sv
// clock_step_sequencer: staged reset release (bit 0 first) followed by a
// CPU clock-enable gate with RUN / SLOW / STEP / HALT modes, all on one clock.
// Optional macro CE_COUNTER_EN adds a 32-bit count of cpu_ce=1 cycles.
module clock_step_sequencer #(
    parameter int NB_DOMAINS  = 3,
    parameter int HOLD_CYCLES = 4096,
    parameter int STAGE_GAP   = 16,
    parameter int DIV_BITS    = 20
) (
    input  logic                  clk,
    input  logic                  resetn,
    clock_step_sequencer_if.slave sif
);
    localparam int HW  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int GW  = (STAGE_GAP > 1)   ? $clog2(STAGE_GAP)   : 1;
    localparam int NDW = (NB_DOMAINS > 1)  ? $clog2(NB_DOMAINS)  : 1;

    localparam logic [HW-1:0]         HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [GW-1:0]         GAP_LAST  = GW'(STAGE_GAP - 1);
    localparam logic [NDW-1:0]        DOM_LAST  = NDW'(NB_DOMAINS - 1);
    localparam logic [NB_DOMAINS-1:0] DOM_ONE   = NB_DOMAINS'(1);

    localparam logic [1:0] M_RUN  = 2'b00;
    localparam logic [1:0] M_SLOW = 2'b01;
    localparam logic [1:0] M_STEP = 2'b10;

    typedef enum logic [1:0] {ST_HOLD, ST_STAGGER, ST_ACTIVE} state_t;

    state_t                r_state, w_state_nxt;
    logic [HW-1:0]         r_hold_cnt, w_hold_cnt_nxt;
    logic [GW-1:0]         r_gap_cnt, w_gap_cnt_nxt;
    logic [NDW-1:0]        r_dom_idx, w_dom_idx_nxt, w_idx_inc;
    logic [NB_DOMAINS-1:0] r_dom_rstn, w_dom_rstn_nxt;
    logic                  r_ready, w_ready_nxt;
    logic                  r_cpu_ce, w_cpu_ce_nxt;
    logic                  r_busy, w_busy_nxt;
    logic [7:0]            r_burst, w_burst_nxt;
    logic [DIV_BITS-1:0]   r_div, w_div_nxt;
    logic                  r_slow_q;
    logic                  r_step_q;
    logic                  w_slow;
    logic                  w_step_rise;

    // SLOW counts only while the sequencer is ACTIVE; the first such edge clears the divider
    assign w_slow      = (r_state == ST_ACTIVE) && (sif.mode == M_SLOW);
    assign w_step_rise = sif.step & ~r_step_q;
    assign w_idx_inc   = r_dom_idx + NDW'(1);

    // FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= ST_HOLD;
        else         r_state <= w_state_nxt;
    end

    // Reset sequencing: hold window, then one domain released every STAGE_GAP edges
    always_comb begin
        w_state_nxt    = r_state;
        w_hold_cnt_nxt = r_hold_cnt;
        w_gap_cnt_nxt  = r_gap_cnt;
        w_dom_idx_nxt  = r_dom_idx;
        w_dom_rstn_nxt = r_dom_rstn;
        w_ready_nxt    = r_ready;
        if (sif.sw_reset_req) begin
            w_state_nxt    = ST_HOLD;
            w_hold_cnt_nxt = '0;
            w_gap_cnt_nxt  = '0;
            w_dom_idx_nxt  = '0;
            w_dom_rstn_nxt = '0;
            w_ready_nxt    = 1'b0;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    if (r_hold_cnt == HOLD_LAST) begin
                        w_hold_cnt_nxt = '0;
                        w_dom_rstn_nxt = DOM_ONE;
                        w_dom_idx_nxt  = '0;
                        if (NB_DOMAINS == 1) begin
                            w_ready_nxt = 1'b1;
                            w_state_nxt = ST_ACTIVE;
                        end else begin
                            w_state_nxt = ST_STAGGER;
                        end
                    end else begin
                        w_hold_cnt_nxt = r_hold_cnt + HW'(1);
                    end
                end
                ST_STAGGER: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        w_gap_cnt_nxt  = '0;
                        w_dom_idx_nxt  = w_idx_inc;
                        w_dom_rstn_nxt = r_dom_rstn | (DOM_ONE << w_idx_inc);
                        if (w_idx_inc == DOM_LAST) begin
                            w_ready_nxt = 1'b1;
                            w_state_nxt = ST_ACTIVE;
                        end
                    end else begin
                        w_gap_cnt_nxt = r_gap_cnt + GW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Clock-enable gating; a burst is dropped as soon as the mode leaves STEP
    always_comb begin
        w_cpu_ce_nxt = 1'b0;
        w_busy_nxt   = r_busy;
        w_burst_nxt  = r_burst;
        w_div_nxt    = '0;
        if (sif.sw_reset_req || (r_state != ST_ACTIVE)) begin
            w_busy_nxt  = 1'b0;
            w_burst_nxt = '0;
        end else begin
            case (sif.mode)
                M_RUN: w_cpu_ce_nxt = 1'b1;
                M_SLOW: begin
                    if (r_slow_q) begin
                        w_div_nxt    = r_div + DIV_BITS'(1);
                        w_cpu_ce_nxt = (w_div_nxt == '0);
                    end
                end
                M_STEP: begin
                    if (r_busy) begin
                        if (r_burst != '0) begin
                            w_cpu_ce_nxt = 1'b1;
                            w_burst_nxt  = r_burst - 8'd1;
                        end else begin
                            w_busy_nxt = 1'b0;
                        end
                    end else if (w_step_rise) begin
                        w_busy_nxt  = 1'b1;
                        w_burst_nxt = (sif.step_count == 8'd0) ? 8'd1 : sif.step_count;
                    end
                end
                default: ;
            endcase
            if (r_busy && (sif.mode != M_STEP)) begin
                w_busy_nxt  = 1'b0;
                w_burst_nxt = '0;
            end
        end
    end

    // Datapath registers; resetn forces everything to the reset values immediately
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hold_cnt <= '0;
            r_gap_cnt  <= '0;
            r_dom_idx  <= '0;
            r_dom_rstn <= '0;
            r_ready    <= 1'b0;
            r_cpu_ce   <= 1'b0;
            r_busy     <= 1'b0;
            r_burst    <= '0;
            r_div      <= '0;
            r_slow_q   <= 1'b0;
            r_step_q   <= 1'b0;
        end else begin
            r_hold_cnt <= w_hold_cnt_nxt;
            r_gap_cnt  <= w_gap_cnt_nxt;
            r_dom_idx  <= w_dom_idx_nxt;
            r_dom_rstn <= w_dom_rstn_nxt;
            r_ready    <= w_ready_nxt;
            r_cpu_ce   <= w_cpu_ce_nxt;
            r_busy     <= w_busy_nxt;
            r_burst    <= w_burst_nxt;
            r_div      <= w_div_nxt;
            r_slow_q   <= w_slow && !sif.sw_reset_req;
            r_step_q   <= sif.step;
        end
    end

`ifdef CE_COUNTER_EN
    logic [31:0] r_ce_count;

    // Running count of enabled cycles, wraps modulo 2^32
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)               r_ce_count <= '0;
        else if (sif.sw_reset_req) r_ce_count <= '0;
        else                       r_ce_count <= r_ce_count + 32'(r_cpu_ce);
    end

    assign sif.ce_count = r_ce_count;
`endif

    assign sif.domain_resetn = r_dom_rstn;
    assign sif.cpu_ce        = r_cpu_ce;
    assign sif.busy          = r_busy;
    assign sif.ready         = r_ready;
endmodule
